// File: rtl/exu_trap_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : exu_trap_ctrl
// Brief    : Execute-stage trap/return sequencer. At each commit it retires
//            normally, takes an interrupt, takes an exception or performs mret,
//            drives the CSR file's trap-side strobes, then flushes the pipeline
//            and redirects fetch through a two-phase handshake.
// Ports    : clk, rst_n              - clock, async active-low reset
//            cmt_*                   - commit interface (cmt_ready out)
//            mstatus_mie, mie_bits,
//            mip_bits, mtvec, mepc   - CSR state inputs
//            in_retr, trap_ena,
//            mret_ena, epc_*, cause_*,
//            tval_wdat               - CSR-side pulses / write data
//            flush_req / flush_ack   - pipeline flush handshake
//            redir_* / redir_ready   - fetch redirect handshake
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module exu_trap_ctrl #(
    parameter bit VEC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmt_valid,
    output logic        cmt_ready,
    input  logic [31:0] cmt_pc,
    input  logic [31:0] cmt_instr,
    input  logic        cmt_ill,
    input  logic        cmt_ecall,
    input  logic        cmt_ebreak,
    input  logic        cmt_mret,
    input  logic        mstatus_mie,
    input  logic [2:0]  mie_bits,
    input  logic [2:0]  mip_bits,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        in_retr,
    output logic        trap_ena,
    output logic        mret_ena,
    output logic        epc_en,
    output logic [31:0] epc_pc,
    output logic        cause_wen,
    output logic [31:0] cause_wdat,
    output logic [31:0] tval_wdat,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_target;
    logic [31:0] w_target_nxt;

    // Pending-and-enabled interrupt lines, bit order {MEI, MTI, MSI}
    logic [2:0]  w_irq_lines;
    logic        w_irq;
    logic [3:0]  w_irq_code;
    logic        w_exc;
    logic [3:0]  w_exc_code;
    logic [31:0] w_base;
    logic        w_vec_ok;
    logic [31:0] w_irq_target;

    assign w_irq_lines = mie_bits & mip_bits;
    assign w_irq       = mstatus_mie & (|w_irq_lines);
    // MEI > MSI > MTI
    assign w_irq_code  = w_irq_lines[2] ? 4'd11 :
                         w_irq_lines[0] ? 4'd3  : 4'd7;

    assign w_exc       = cmt_ill | cmt_ebreak | cmt_ecall;
    assign w_exc_code  = cmt_ill    ? 4'd2 :
                         cmt_ebreak ? 4'd3 : 4'd11;

    assign w_base      = mtvec & 32'hFFFF_FFFC;

    // Only mode 01 is vectored; 10/11 fall back to direct
    generate
        if (VEC_EN) begin : g_vec
            assign w_vec_ok = (mtvec[1:0] == 2'b01);
        end else begin : g_direct
            assign w_vec_ok = 1'b0;
        end
    endgenerate

    assign w_irq_target = w_vec_ok ? (w_base + {26'd0, w_irq_code, 2'b00}) : w_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_target <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        cmt_ready    = 1'b0;
        in_retr      = 1'b0;
        trap_ena     = 1'b0;
        mret_ena     = 1'b0;
        epc_pc       = 32'd0;
        cause_wdat   = 32'd0;
        tval_wdat    = 32'd0;
        flush_req    = 1'b0;
        redir_valid  = 1'b0;
        redir_pc     = 32'd0;

        case (r_state)
            ST_IDLE: begin
                cmt_ready = 1'b1;
                if (cmt_valid) begin
                    if (w_irq) begin
                        // Interrupted instruction is not executed
                        trap_ena     = 1'b1;
                        epc_pc       = cmt_pc;
                        cause_wdat   = {1'b1, 27'd0, w_irq_code};
                        w_target_nxt = w_irq_target;
                        w_state_nxt  = ST_FLUSH;
                    end else if (w_exc) begin
                        trap_ena     = 1'b1;
                        epc_pc       = cmt_pc;
                        cause_wdat   = {1'b0, 27'd0, w_exc_code};
                        tval_wdat    = cmt_ill ? cmt_instr : 32'd0;
                        w_target_nxt = w_base;
                        w_state_nxt  = ST_FLUSH;
                    end else if (cmt_mret) begin
                        mret_ena     = 1'b1;
                        w_target_nxt = mepc & 32'hFFFF_FFFE;
                        w_state_nxt  = ST_FLUSH;
                    end else begin
                        in_retr = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                flush_req = 1'b1;
                if (flush_ack) begin
                    w_state_nxt = ST_REDIR;
                end
            end
            ST_REDIR: begin
                redir_valid = 1'b1;
                redir_pc    = r_target;
                if (redir_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // mepc and mcause/mtval are written together with trap entry
    assign epc_en    = trap_ena;
    assign cause_wen = trap_ena;

endmodule
`default_nettype wire

// File: tb/tb_exu_trap_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_exu_trap_ctrl
// Brief    : Self-checking bench for exu_trap_ctrl. Two instances (vectored and
//            direct) share stimulus; a behavioural model predicts outputs every
//            cycle, and directed scenarios pin literal values.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_exu_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmt_valid, cmt_ill, cmt_ecall, cmt_ebreak, cmt_mret;
    logic [31:0] cmt_pc, cmt_instr, mtvec, mepc;
    logic        mstatus_mie, flush_ack, redir_ready;
    logic [2:0]  mie_bits, mip_bits;

    // Vectored instance outputs
    logic        cmt_ready, in_retr, trap_ena, mret_ena, epc_en, cause_wen;
    logic        flush_req, redir_valid;
    logic [31:0] epc_pc, cause_wdat, tval_wdat, redir_pc;
    // Direct-only instance outputs
    logic        d_cmt_ready, d_in_retr, d_trap_ena, d_mret_ena, d_epc_en, d_cause_wen;
    logic        d_flush_req, d_redir_valid;
    logic [31:0] d_epc_pc, d_cause_wdat, d_tval_wdat, d_redir_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exu_trap_ctrl #(.VEC_EN(1'b1)) u_dut_vec (
        .clk(clk), .rst_n(rst_n), .cmt_valid(cmt_valid), .cmt_ready(cmt_ready),
        .cmt_pc(cmt_pc), .cmt_instr(cmt_instr), .cmt_ill(cmt_ill), .cmt_ecall(cmt_ecall),
        .cmt_ebreak(cmt_ebreak), .cmt_mret(cmt_mret), .mstatus_mie(mstatus_mie),
        .mie_bits(mie_bits), .mip_bits(mip_bits), .mtvec(mtvec), .mepc(mepc),
        .in_retr(in_retr), .trap_ena(trap_ena), .mret_ena(mret_ena), .epc_en(epc_en),
        .epc_pc(epc_pc), .cause_wen(cause_wen), .cause_wdat(cause_wdat),
        .tval_wdat(tval_wdat), .flush_req(flush_req), .flush_ack(flush_ack),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready)
    );

    exu_trap_ctrl #(.VEC_EN(1'b0)) u_dut_dir (
        .clk(clk), .rst_n(rst_n), .cmt_valid(cmt_valid), .cmt_ready(d_cmt_ready),
        .cmt_pc(cmt_pc), .cmt_instr(cmt_instr), .cmt_ill(cmt_ill), .cmt_ecall(cmt_ecall),
        .cmt_ebreak(cmt_ebreak), .cmt_mret(cmt_mret), .mstatus_mie(mstatus_mie),
        .mie_bits(mie_bits), .mip_bits(mip_bits), .mtvec(mtvec), .mepc(mepc),
        .in_retr(d_in_retr), .trap_ena(d_trap_ena), .mret_ena(d_mret_ena), .epc_en(d_epc_en),
        .epc_pc(d_epc_pc), .cause_wen(d_cause_wen), .cause_wdat(d_cause_wdat),
        .tval_wdat(d_tval_wdat), .flush_req(d_flush_req), .flush_ack(flush_ack),
        .redir_valid(d_redir_valid), .redir_pc(d_redir_pc), .redir_ready(redir_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    //--------------------------------------------------------------------------
    // Behavioural model: phase 0 = accepting commits, 1 = waiting for flush,
    // 2 = offering redirect. Targets are kept for both instances.
    //--------------------------------------------------------------------------
    int          m_phase = 0;
    int          m_phase_nxt;
    logic [31:0] m_tgt_v = 32'd0, m_tgt_d = 32'd0;
    logic [31:0] m_tgt_v_nxt, m_tgt_d_nxt;
    logic [7:0]  e_ctl;
    logic [31:0] e_epc, e_cause, e_tval, e_rpc_v, e_rpc_d;
    logic [2:0]  m_lines;
    int          m_code;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_tgt_v <= 32'd0;
            m_tgt_d <= 32'd0;
        end else begin
            m_phase <= m_phase_nxt;
            m_tgt_v <= m_tgt_v_nxt;
            m_tgt_d <= m_tgt_d_nxt;
        end
    end

    // ctl packing: {cmt_ready,in_retr,trap_ena,mret_ena,epc_en,cause_wen,flush_req,redir_valid}
    always @(negedge clk) begin
        e_ctl = 8'd0; e_epc = 0; e_cause = 0; e_tval = 0; e_rpc_v = 0; e_rpc_d = 0;
        m_phase_nxt = m_phase; m_tgt_v_nxt = m_tgt_v; m_tgt_d_nxt = m_tgt_d;
        if (!rst_n) begin
            e_ctl = 8'b1000_0000;
        end else if (m_phase == 0) begin
            e_ctl[7] = 1'b1;
            m_lines = mie_bits & mip_bits;
            if (cmt_valid && mstatus_mie && m_lines != 3'b000) begin
                m_code  = m_lines[2] ? 11 : (m_lines[0] ? 3 : 7);
                e_ctl   = 8'b1010_1100;
                e_epc   = cmt_pc;
                e_cause = 32'h8000_0000 + m_code;
                m_tgt_d_nxt = mtvec & ~32'd3;
                m_tgt_v_nxt = (mtvec & ~32'd3) + ((mtvec[1:0] == 2'b01) ? m_code * 4 : 0);
                m_phase_nxt = 1;
            end else if (cmt_valid && (cmt_ill || cmt_ebreak || cmt_ecall)) begin
                m_code  = cmt_ill ? 2 : (cmt_ebreak ? 3 : 11);
                e_ctl   = 8'b1010_1100;
                e_epc   = cmt_pc;
                e_cause = m_code;
                e_tval  = cmt_ill ? cmt_instr : 32'd0;
                m_tgt_d_nxt = mtvec & ~32'd3;
                m_tgt_v_nxt = mtvec & ~32'd3;
                m_phase_nxt = 1;
            end else if (cmt_valid && cmt_mret) begin
                e_ctl = 8'b1001_0000;
                m_tgt_d_nxt = mepc & ~32'd1;
                m_tgt_v_nxt = mepc & ~32'd1;
                m_phase_nxt = 1;
            end else if (cmt_valid) begin
                e_ctl = 8'b1100_0000;
            end
        end else if (m_phase == 1) begin
            e_ctl = 8'b0000_0010;
            if (flush_ack) m_phase_nxt = 2;
        end else begin
            e_ctl   = 8'b0000_0001;
            e_rpc_v = m_tgt_v;
            e_rpc_d = m_tgt_d;
            if (redir_ready) m_phase_nxt = 0;
        end
        check("ctl_vec", {24'd0, cmt_ready, in_retr, trap_ena, mret_ena, epc_en, cause_wen,
                          flush_req, redir_valid}, {24'd0, e_ctl});
        check("ctl_dir", {24'd0, d_cmt_ready, d_in_retr, d_trap_ena, d_mret_ena, d_epc_en,
                          d_cause_wen, d_flush_req, d_redir_valid}, {24'd0, e_ctl});
        check("epc_pc", epc_pc, e_epc);
        check("cause", cause_wdat, e_cause);
        check("tval", tval_wdat, e_tval);
        check("redir_pc_vec", redir_pc, e_rpc_v);
        check("redir_pc_dir", d_redir_pc, e_rpc_d);
    end

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cmt_valid = 0; cmt_ill = 0; cmt_ecall = 0; cmt_ebreak = 0; cmt_mret = 0;
        flush_ack = 0; redir_ready = 0;
    endtask

    // Leave FLUSH and REDIR with immediate handshakes
    task automatic finish_seq();
        flush_ack = 1; tick(); flush_ack = 0;
        redir_ready = 1; tick(); redir_ready = 0;
    endtask

    initial begin
        rst_n = 0;
        quiet();
        cmt_pc = 0; cmt_instr = 0; mtvec = 0; mepc = 0;
        mstatus_mie = 0; mie_bits = 0; mip_bits = 0;
        tick(); tick();
        #3;
        check("rst_cmt_ready", {31'd0, cmt_ready}, 32'd1);
        check("rst_redir_pc", redir_pc, 32'd0);
        tick();
        rst_n = 1;

        // Normal retire
        cmt_valid = 1; cmt_pc = 32'h40;
        #3;
        check("norm_in_retr", {31'd0, in_retr}, 32'd1);
        check("norm_trap", {31'd0, trap_ena}, 32'd0);
        tick(); quiet();

        // Illegal instruction, delayed flush_ack
        cmt_valid = 1; cmt_ill = 1; cmt_pc = 32'h100; cmt_instr = 32'hFFFF_FFFF;
        mtvec = 32'h8000_0001;
        #3;
        check("ill_trap", {29'd0, trap_ena, epc_en, cause_wen}, 32'd7);
        check("ill_epc", epc_pc, 32'h100);
        check("ill_cause", cause_wdat, 32'd2);
        check("ill_tval", tval_wdat, 32'hFFFF_FFFF);
        tick(); quiet();
        for (int i = 0; i < 3; i++) begin
            check("ill_wait_ready", {30'd0, cmt_ready, flush_req}, 32'd1);
            tick();
        end
        flush_ack = 1; tick(); flush_ack = 0;
        check("ill_redir", redir_pc, 32'h8000_0000);
        redir_ready = 1; tick(); redir_ready = 0;

        // Vectored timer interrupt
        mstatus_mie = 1; mie_bits = 3'b010; mip_bits = 3'b010;
        cmt_valid = 1; cmt_pc = 32'h200;
        #3;
        check("tmr_cause", cause_wdat, 32'h8000_0007);
        tick(); quiet();
        flush_ack = 1; tick(); flush_ack = 0;
        check("tmr_redir_vec", redir_pc, 32'h8000_001C);
        check("tmr_redir_dir", d_redir_pc, 32'h8000_0000);
        redir_ready = 1; tick(); redir_ready = 0;

        // All interrupts plus ecall; then with MIE cleared
        mie_bits = 3'b111; mip_bits = 3'b111;
        cmt_valid = 1; cmt_ecall = 1; cmt_pc = 32'h300;
        #3;
        check("pri_cause", cause_wdat, 32'h8000_000B);
        check("pri_epc", epc_pc, 32'h300);
        tick(); quiet(); finish_seq();
        mstatus_mie = 0;
        cmt_valid = 1; cmt_ecall = 1;
        #3;
        check("ecall_cause", cause_wdat, 32'd11);
        tick(); quiet(); finish_seq();

        // mret
        mepc = 32'h203; cmt_valid = 1; cmt_mret = 1;
        #3;
        check("mret_pulses", {29'd0, mret_ena, trap_ena, in_retr}, 32'd4);
        tick(); quiet();
        flush_ack = 1; tick(); flush_ack = 0;
        check("mret_redir", redir_pc, 32'h202);

        // Reset while offering the redirect
        #3;
        rst_n = 0;
        #1;
        check("rst_mid_redir", {30'd0, cmt_ready, redir_valid}, 32'd2);
        check("rst_mid_redir_pc", redir_pc, 32'd0);
        tick();
        rst_n = 1;
        cmt_valid = 1; cmt_ecall = 1; cmt_pc = 32'h500;
        #3;
        check("post_rst_ecall", cause_wdat, 32'd11);
        tick(); quiet(); finish_seq();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cmt_valid   = ($urandom_range(0, 3) != 0);
            cmt_pc      = $urandom;
            cmt_instr   = $urandom;
            cmt_ill     = ($urandom_range(0, 7) == 0);
            cmt_ecall   = ($urandom_range(0, 7) == 0);
            cmt_ebreak  = ($urandom_range(0, 7) == 0);
            cmt_mret    = ($urandom_range(0, 5) == 0);
            mstatus_mie = ($urandom_range(0, 2) == 0);
            mie_bits    = 3'($urandom);
            mip_bits    = 3'($urandom);
            mtvec       = $urandom;
            mepc        = $urandom;
            flush_ack   = $urandom_range(0, 1) == 1;
            redir_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        quiet();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exu_trap_ctrl.md
Name: exu_trap_ctrl

Overview:
- Trap/return sequencer for the execute stage.
- At each commit boundary it decides whether to retire normally, take an interrupt, take an exception, or execute mret.
- It drives the CSR file's trap-side controls: trap_ena, mret_ena, epc_en/epc_pc, mcause/mtval write.
- It then flushes the pipeline and redirects fetch through a two-phase handshake. This gives the CSR file a single, serialized source of trap events.

Parameters:
VEC_EN  1  1 = honour mtvec vectored mode (mtvec[1:0]==01) for interrupts; 0 = always direct

Ports:
clk            in   1   clock
rst_n          in   1   asynchronous active-low reset
cmt_valid      in   1   instruction at commit
cmt_ready      out  1   commit accepted this cycle; high only in IDLE
cmt_pc         in   32  PC of committing instruction
cmt_instr      in   32  raw instruction word
cmt_ill        in   1   illegal instruction
cmt_ecall      in   1   ecall
cmt_ebreak     in   1   ebreak
cmt_mret       in   1   mret
mstatus_mie    in   1   mstatus.MIE from CSR file
mie_bits       in   3   {MEIE,MTIE,MSIE}
mip_bits       in   3   {MEIP,MTIP,MSIP}
mtvec          in   32  mtvec CSR value
mepc           in   32  mepc CSR value
in_retr        out  1   normal retirement pulse (to minstret)
trap_ena       out  1   one-cycle trap-entry pulse
mret_ena       out  1   one-cycle mret pulse
epc_en         out  1   mepc write strobe (equals trap_ena)
epc_pc         out  32  value written to mepc
cause_wen      out  1   mcause/mtval write strobe (equals trap_ena)
cause_wdat     out  32  mcause value
tval_wdat      out  32  mtval value
flush_req      out  1   pipeline flush request
flush_ack      in   1   flush complete
redir_valid    out  1   fetch redirect valid
redir_pc       out  32  redirect target
redir_ready    in   1   fetch accepted redirect

Behaviour:
- Reset (async, rst_n=0): state=IDLE, target register=0. All outputs 0 except cmt_ready=1. Reset mid-FLUSH or mid-REDIR abandons the sequence; no further pulses.
- States: IDLE, FLUSH, REDIR. Encoded in a registered state variable.
- IDLE, cmt_valid=0: no action, all pulses 0.
- IDLE, cmt_valid=1: evaluate in priority order; exactly one outcome per commit.
  1. Interrupt: irq = mstatus_mie & |(mie_bits & mip_bits).
     - Cause priority MEI(11) > MSI(3) > MTI(7); cause_wdat = {1'b1, 27'b0, code}, tval_wdat=0.
     - The committing instruction is NOT executed (no mret, no retire); epc_pc = cmt_pc.
  2. Exception: priority ill(2) > ebreak(3) > ecall(11); cause_wdat = {1'b0, 27'b0, code}.
     - tval_wdat = cmt_instr for ill, else 0.
     - epc_pc = cmt_pc.
  3. mret: mret_ena=1; target = {mepc[31:1], 1'b0}.
  4. Otherwise: in_retr=1; stay IDLE.
- Cases 1–3 are combinational same-cycle pulses:
  - Cases 1–2 assert trap_ena=epc_en=cause_wen=1.
  - Any of cases 1–3 latches the target into a register and moves to FLUSH next cycle.
  - in_retr=0 for cases 1–3.
- Trap target:
  - Base = {mtvec[31:2], 2'b00}.
  - If VEC_EN=1, mtvec[1:0]==01 and interrupt: target = base + (code << 2).
  - Otherwise target = base. mtvec[1:0] values 10/11 are treated as direct.
- FLUSH:
  - flush_req=1, cmt_ready=0.
  - On flush_ack=1, go to REDIR next cycle. An ack already high in the first FLUSH cycle is valid (minimum 1 cycle in FLUSH).
- REDIR:
  - redir_valid=1; redir_pc = latched target, held stable until handshake.
  - cmt_ready=0.
  - On redir_ready=1, go to IDLE next cycle.
- Latency: decision cycle T; flush_req earliest at T+1; redir_valid earliest at T+2; next commit accepted earliest at T+3.
- Interrupt changes and cmt_* inputs are ignored outside IDLE. The CSR file's MIE update from trap/mret is visible by the next IDLE.
- Invariants:
  - trap_ena and mret_ena are never both high.
  - flush_req and redir_valid are never both high.
  - No pulse is issued outside IDLE.

Test Plan:
- Normal commit: cmt_valid=1, no flags → in_retr=1, cmt_ready=1, no trap_ena, state stays IDLE.
- Illegal instr: cmt_pc=0x100, cmt_instr=0xFFFFFFFF, mtvec=0x8000_0001 → trap_ena/epc_en/cause_wen=1 for one cycle, epc_pc=0x100, cause=2, tval=0xFFFFFFFF. Redirect to 0x8000_0000 (exceptions use direct mode). flush_ack delayed 3 cycles → cmt_ready stays 0 throughout.
- Vectored timer irq: MIE=1, mie_bits=010, mip_bits=010, mtvec=0x8000_0001 → cause=0x8000_0007, redir_pc=0x8000_001C; with VEC_EN=0 → 0x8000_0000.
- Priority: all irqs pending and enabled plus cmt_ecall → cause=0x8000_000B, epc=cmt_pc, no ecall cause. Repeat with MIE=0 → cause=11.
- mret: mepc=0x203 → mret_ena=1, trap_ena=0, redir_pc=0x202, in_retr=0.
- Reset mid-REDIR with redir_ready=0 → all outputs 0, cmt_ready=1 immediately. A following ecall is handled normally.
